// File: rtl/instruction_encode_loader.sv
// instruction_encode_loader
// Packs decoded instruction fields into the 32-bit decode-stage format and
// writes each word into instruction memory at an auto-incrementing address.
// Branches take an absolute byte target and are stored as a PC-relative word
// offset. A misaligned or out-of-range branch stops the session in ERR.
//
// Ports:
//   clk, rstN              clock (rising edge), async active-low reset
//   start, startAddr       begin a load session at the given word address
//   inValid / inReady      instruction field handshake
//   last                   marks the final instruction of the session
//   isBranch, opcode, iOrReg, rd, rs1, rs2, modifier, imm, branchTarget
//                          decoded instruction fields
//   memWe, memAddr, memData  instruction memory write port
//   count                  words written this session
//   busy, loaded, error    session status (LOAD/WRITE, DONE, ERR)
module instruction_encode_loader #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rstN,
    input  logic              start,
    input  logic [ADDR_W-1:0] startAddr,
    input  logic              inValid,
    output logic              inReady,
    input  logic              last,
    input  logic              isBranch,
    input  logic [4:0]        opcode,
    input  logic              iOrReg,
    input  logic [3:0]        rd,
    input  logic [3:0]        rs1,
    input  logic [3:0]        rs2,
    input  logic [1:0]        modifier,
    input  logic [15:0]       imm,
    input  logic [31:0]       branchTarget,
    output logic              memWe,
    output logic [ADDR_W-1:0] memAddr,
    output logic [31:0]       memData,
    output logic [ADDR_W:0]   count,
    output logic              busy,
    output logic              loaded,
    output logic              error
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam logic [ADDR_W-1:0] PTR_MAX = '1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        WRITE = 3'd2,
        DONE  = 3'd3,
        ERR   = 3'd4
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] ptr_q;
    logic              last_q;

    logic [31:0]       pc_c;
    logic [31:0]       diff_c;
    logic              br_err_c;
    logic [31:0]       word_c;

    // Encoder: byte PC of the slot being filled, branch offset and range check.
    always_comb begin
        pc_c                 = '0;
        pc_c[ADDR_W+1:0]     = {ptr_q, 2'b00};
        diff_c               = branchTarget - pc_c;
        // Offset must be word aligned and fit a signed 27-bit word count.
        br_err_c = (diff_c[1:0] != 2'b00) ||
                   !((diff_c[31:28] == 4'h0) || (diff_c[31:28] == 4'hF));
        if (isBranch) begin
            word_c = {opcode, diff_c[28:2]};
        end else if (iOrReg) begin
            word_c = {opcode, 1'b1, rd, rs1, modifier, imm};
        end else begin
            word_c = {opcode, 1'b0, rd, rs1, rs2, 14'h0000};
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE, ERR: begin
                if (start) state_d = LOAD;
            end
            LOAD: begin
                if (inValid) state_d = (isBranch && br_err_c) ? ERR : WRITE;
            end
            WRITE: begin
                // The top word ends the session; the pointer never wraps.
                state_d = (last_q || (ptr_q == PTR_MAX)) ? DONE : LOAD;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Registered status outputs track the state being entered.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            inReady <= 1'b0;
            memWe   <= 1'b0;
            busy    <= 1'b0;
            loaded  <= 1'b0;
            error   <= 1'b0;
        end else begin
            inReady <= (state_d == LOAD);
            memWe   <= (state_d == WRITE);
            busy    <= (state_d == LOAD) || (state_d == WRITE);
            loaded  <= (state_d == DONE);
            error   <= (state_d == ERR);
        end
    end

    // Write pointer, word count and the captured memory write payload.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            ptr_q   <= '0;
            count   <= '0;
            last_q  <= 1'b0;
            memAddr <= '0;
            memData <= '0;
        end else begin
            case (state_q)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        ptr_q <= startAddr;
                        count <= '0;
                    end
                end
                LOAD: begin
                    if (state_d == WRITE) begin
                        memAddr <= ptr_q;
                        memData <= word_c;
                        last_q  <= last;
                    end
                end
                WRITE: begin
                    ptr_q <= ptr_q + ADDR_W'(1);
                    count <= count + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_encode_loader.sv
// Directed bench for instruction_encode_loader with a transaction-level model
// and a per-cycle output comparison.
module tb_instruction_encode_loader;

    localparam int unsigned ADDR_W = 8;
    localparam int PTR_TOP = (1 << ADDR_W) - 1;

    logic              clk;
    logic              rstN;
    logic              start;
    logic [ADDR_W-1:0] startAddr;
    logic              inValid;
    logic              inReady;
    logic              last;
    logic              isBranch;
    logic [4:0]        opcode;
    logic              iOrReg;
    logic [3:0]        rd;
    logic [3:0]        rs1;
    logic [3:0]        rs2;
    logic [1:0]        modifier;
    logic [15:0]       imm;
    logic [31:0]       branchTarget;
    logic              memWe;
    logic [ADDR_W-1:0] memAddr;
    logic [31:0]       memData;
    logic [ADDR_W:0]   count;
    logic              busy;
    logic              loaded;
    logic              error;

    int n_checks = 0;
    int n_fail   = 0;
    bit checking = 0;

    instruction_encode_loader #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rstN(rstN), .start(start), .startAddr(startAddr),
        .inValid(inValid), .inReady(inReady), .last(last),
        .isBranch(isBranch), .opcode(opcode), .iOrReg(iOrReg),
        .rd(rd), .rs1(rs1), .rs2(rs2), .modifier(modifier), .imm(imm),
        .branchTarget(branchTarget), .memWe(memWe), .memAddr(memAddr),
        .memData(memData), .count(count), .busy(busy), .loaded(loaded),
        .error(error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Encoding rules in plain arithmetic; bit 32 flags an unencodable branch.
    function automatic logic [32:0] menc(input logic br, input logic ir,
                                         input logic [4:0] op, input logic [3:0] f_rd,
                                         input logic [3:0] f_rs1, input logic [3:0] f_rs2,
                                         input logic [1:0] md, input logic [15:0] im,
                                         input logic [31:0] tgt, input int ptr);
        longint w;
        longint sd;
        logic [31:0] d;
        bit e;
        e = 0;
        if (br) begin
            d  = tgt - 32'(ptr * 4);
            sd = longint'($signed(d));
            e  = (d % 32'd4 != 0) || (sd < -268435456) || (sd >= 268435456);
            w  = longint'(op) * 134217728 + ((sd / 4) & 64'h7FFFFFF);
        end else if (ir) begin
            w = longint'(op) * 134217728 + 67108864 + longint'(f_rd) * 4194304 +
                longint'(f_rs1) * 262144 + longint'(md) * 65536 + longint'(im);
        end else begin
            w = longint'(op) * 134217728 + longint'(f_rd) * 4194304 +
                longint'(f_rs1) * 262144 + longint'(f_rs2) * 16384;
        end
        return {e, 32'(w)};
    endfunction

    // Model: a session accepts one instruction, spends one cycle writing it,
    // and ends on last, on the top address, or on a bad branch.
    bit          m_ready = 0, m_we = 0, m_done = 0, m_err = 0, m_last = 0;
    int          m_ptr = 0, m_count = 0, m_addr = 0;
    logic [31:0] m_word = '0;
    logic [32:0] m_enc;

    always_comb m_enc = menc(isBranch, iOrReg, opcode, rd, rs1, rs2, modifier, imm,
                             branchTarget, m_ptr);

    always @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            m_ready <= 0; m_we <= 0; m_done <= 0; m_err <= 0; m_last <= 0;
            m_ptr <= 0; m_count <= 0; m_addr <= 0; m_word <= '0;
        end else if (m_we) begin
            m_we    <= 0;
            m_count <= m_count + 1;
            m_ptr   <= (m_ptr + 1) % (PTR_TOP + 1);
            if (m_last || m_ptr == PTR_TOP) m_done <= 1;
            else m_ready <= 1;
        end else if (m_ready) begin
            if (inValid) begin
                m_ready <= 0;
                if (m_enc[32]) begin
                    m_err <= 1;
                end else begin
                    m_we   <= 1;
                    m_word <= m_enc[31:0];
                    m_addr <= m_ptr;
                    m_last <= last;
                end
            end
        end else if (start) begin
            m_ready <= 1; m_done <= 0; m_err <= 0;
            m_ptr <= int'(startAddr); m_count <= 0;
        end
    end

    // Per-cycle comparison on the falling edge.
    always @(negedge clk) begin
        if (checking) begin
            chk("inReady", inReady, m_ready);
            chk("memWe",   memWe,   m_we);
            chk("memAddr", memAddr, m_addr);
            chk("memData", memData, m_word);
            chk("count",   count,   m_count);
            chk("busy",    busy,    m_ready | m_we);
            chk("loaded",  loaded,  m_done);
            chk("error",   error,   m_err);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_reg(input logic [4:0] op, input logic [3:0] a, input logic [3:0] b,
                             input logic [3:0] c, input logic lst);
        isBranch = 0; iOrReg = 0; opcode = op; rd = a; rs1 = b; rs2 = c;
        modifier = 2'd0; imm = 16'h0; last = lst;
    endtask

    task automatic drive_imm(input logic [4:0] op, input logic [3:0] a, input logic [3:0] b,
                             input logic [1:0] md, input logic [15:0] im, input logic lst);
        isBranch = 0; iOrReg = 1; opcode = op; rd = a; rs1 = b; rs2 = 4'd0;
        modifier = md; imm = im; last = lst;
    endtask

    task automatic drive_br(input logic [4:0] op, input logic [31:0] tgt, input logic lst);
        isBranch = 1; iOrReg = 0; opcode = op; branchTarget = tgt; last = lst;
    endtask

    task automatic begin_session(input logic [ADDR_W-1:0] a);
        start = 1; startAddr = a;
        tick();
        start = 0;
    endtask

    initial begin
        rstN = 0; start = 0; startAddr = '0; inValid = 0; last = 0;
        isBranch = 0; opcode = '0; iOrReg = 0; rd = '0; rs1 = '0; rs2 = '0;
        modifier = '0; imm = '0; branchTarget = '0;
        repeat (2) tick();
        rstN = 1;
        chk("rst_inReady", inReady, 0);
        chk("rst_memWe", memWe, 0);
        chk("rst_count", count, 0);
        chk("rst_loaded", loaded, 0);
        chk("rst_error", error, 0);
        checking = 1;

        // Register form.
        begin_session(8'd0);
        chk("t1_ready", inReady, 1);
        drive_reg(5'h03, 4'd1, 4'd2, 4'd3, 0); inValid = 1;
        tick(); inValid = 0;
        chk("t1_we", memWe, 1);
        chk("t1_addr", memAddr, 0);
        chk("t1_data", memData, 32'h1848C000);
        chk("t1_model", m_word, 32'h1848C000);
        tick();
        chk("t1_count", count, 1);
        chk("t1_ready2", inReady, 1);

        // Immediate form closing the session.
        drive_imm(5'h01, 4'd4, 4'd5, 2'd2, 16'h1234, 1); inValid = 1;
        tick(); inValid = 0; last = 0;
        chk("t2_data", memData, 32'h0D161234);
        chk("t2_addr", memAddr, 1);
        tick();
        chk("t2_loaded", loaded, 1);
        chk("t2_ready", inReady, 0);
        chk("t2_count", count, 2);
        tick();
        chk("t2_hold", memData, 32'h0D161234);

        // Backward and forward branches.
        begin_session(8'd4);
        drive_br(5'h10, 32'h0, 1); inValid = 1;
        tick(); inValid = 0; last = 0;
        chk("t3_addr", memAddr, 4);
        chk("t3_back", memData, 32'h87FFFFFC);
        chk("t3_model", m_word, 32'h87FFFFFC);
        tick();
        begin_session(8'd0);
        drive_br(5'h10, 32'h40, 1); inValid = 1;
        tick(); inValid = 0; last = 0;
        chk("t3_fwd", memData, 32'h80000010);
        tick();

        // Misaligned branch, restart, out-of-range branch, largest forward offset.
        begin_session(8'd0);
        drive_br(5'h10, 32'h12, 0); inValid = 1;
        tick(); inValid = 0;
        chk("t4_we", memWe, 0);
        chk("t4_err", error, 1);
        chk("t4_ready", inReady, 0);
        chk("t4_hold", memData, 32'h80000010);
        tick();
        chk("t4_sticky", error, 1);
        begin_session(8'd0);
        chk("t4_clr", error, 0);
        chk("t4_cnt", count, 0);
        chk("t4_load", inReady, 1);
        drive_br(5'h10, 32'h10000000, 0); inValid = 1;
        tick(); inValid = 0;
        chk("t4_range", error, 1);
        begin_session(8'd0);
        drive_br(5'h10, 32'h0FFFFFFC, 1); inValid = 1;
        tick(); inValid = 0; last = 0;
        chk("t4_maxfwd", memData, 32'h83FFFFFF);
        tick();

        // Fill to the top address with inValid held and no last.
        begin_session(8'd254);
        drive_reg(5'h02, 4'd7, 4'd8, 4'd9, 0); inValid = 1;
        tick();
        chk("t5_addr0", memAddr, 254);
        chk("t5_nrdy", inReady, 0);
        tick();
        chk("t5_rdy", inReady, 1);
        tick();
        chk("t5_addr1", memAddr, 255);
        chk("t5_we", memWe, 1);
        tick();
        chk("t5_loaded", loaded, 1);
        chk("t5_count", count, 2);
        repeat (3) tick();
        chk("t5_noacc", memWe, 0);
        chk("t5_count2", count, 2);

        // start wins over a simultaneous inValid.
        drive_reg(5'h04, 4'd1, 4'd1, 4'd1, 1); start = 1; startAddr = 8'd20;
        tick(); start = 0;
        chk("t6_load", inReady, 1);
        chk("t6_nowe", memWe, 0);
        tick(); inValid = 0; last = 0;
        chk("t6_we", memWe, 1);
        chk("t6_addr", memAddr, 20);
        tick();
        chk("t6_cnt", count, 1);

        // Reset during WRITE.
        begin_session(8'd10);
        drive_reg(5'h05, 4'd2, 4'd3, 4'd4, 0); inValid = 1;
        tick(); inValid = 0;
        chk("t7_we", memWe, 1);
        rstN = 0;
        #1;
        chk("t7_we_drop", memWe, 0);
        chk("t7_addr", memAddr, 0);
        chk("t7_data", memData, 0);
        tick(); tick();
        rstN = 1;
        chk("t7_busy", busy, 0);
        chk("t7_count", count, 0);
        chk("t7_ready", inReady, 0);
        repeat (3) tick();
        chk("t7_idle", memWe, 0);

        checking = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
